// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: iterative MUL and DIV/MOD, registered simple ops.
// Define ALU_EXT_FLAGS_EN to add the neg/carry/ovf flag outputs.
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
`ifdef ALU_EXT_FLAGS_EN
   ,output logic             neg,
    output logic             carry,
    output logic             ovf
`endif
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_PASS = 4'd9;
    localparam logic [3:0] ALU_NOT  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_DIV  = 4'd12;
    localparam logic [3:0] ALU_MOD  = 4'd13;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]       r_state;
    logic [SHW-1:0]   r_cnt;
    logic [3:0]       r_op;
    logic             r_sgn;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_ov;

    logic             w_fire;
    logic             w_is_div;
    logic             w_dz;
    logic             w_iter;
    logic             w_load;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_sy;
    logic             w_sz;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_mag;
    logic [WIDTH-1:0] w_fix_y;
    logic [WIDTH-1:0] w_ynext;
    logic             w_znext;

    // One non-restoring step: remainder carries its sign in the top bit.
    function automatic logic [2*WIDTH:0] div_step(
        input logic [WIDTH:0]   rem,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] sh;
        logic [WIDTH:0] nr;
        sh = {rem[WIDTH-1:0], q[WIDTH-1]};
        nr = rem[WIDTH] ? sh + {1'b0, d} : sh - {1'b0, d};
        return {nr, q[WIDTH-2:0], ~nr[WIDTH]};
    endfunction

    assign in_ready = rst_n && (r_state == S_IDLE)
                      && (!r_ov || out_ready) && !flush;
    assign w_fire   = in_valid && in_ready;
    assign w_is_div = (op == ALU_DIV) || (op == ALU_MOD);
    assign w_dz     = w_is_div && (b == '0);
    assign w_iter   = (op == ALU_MUL) || (w_is_div && !w_dz);
    assign w_a_mag  = a[WIDTH-1] ? -a : a;
    assign w_b_mag  = b[WIDTH-1] ? -b : b;

    always_comb begin
        w_sy = '0;
        case (op)
            ALU_ADD:  w_sy = a + b;
            ALU_SUB:  w_sy = a - b;
            ALU_AND:  w_sy = a & b;
            ALU_OR:   w_sy = a | b;
            ALU_XOR:  w_sy = a ^ b;
            ALU_SLT:  w_sy = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLL:  w_sy = a << b[SHW-1:0];
            ALU_SRL:  w_sy = a >> b[SHW-1:0];
            ALU_SRA:  w_sy = $signed(a) >>> b[SHW-1:0];
            ALU_PASS: w_sy = b;
            ALU_NOT:  w_sy = ~b;
            ALU_DIV:  w_sy = '1;
            ALU_MOD:  w_sy = a;
            default:  w_sy = '0;
        endcase
        w_sz = w_dz ? (op == ALU_DIV) : (w_sy == '0);
    end

    assign w_rem = r_acc[WIDTH-1:0] + (r_acc[WIDTH] ? r_d : '0);

    always_comb begin
        w_mag = w_rem;
        if (r_op == ALU_MUL)
            w_mag = r_acc[WIDTH-1:0];
        else if (r_op == ALU_DIV)
            w_mag = r_q;
    end

    assign w_fix_y = r_sgn ? -w_mag : w_mag;
    assign w_load  = (w_fire && !w_iter) || ((r_state == S_FIX) && !flush);
    assign w_ynext = (r_state == S_FIX) ? w_fix_y : w_sy;
    assign w_znext = (r_state == S_FIX) ? (w_fix_y == '0) : w_sz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ov    <= 1'b0;
            r_y     <= '0;
            r_zero  <= 1'b0;
        end else begin
            if (r_ov && out_ready)
                r_ov <= 1'b0;
            if (flush) begin
                r_ov    <= 1'b0;
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (w_fire && w_iter) begin
                        r_op  <= op;
                        r_cnt <= SHW'(WIDTH - 2);
                        // The accept edge already performs the first iteration.
                        if (op == ALU_MUL) begin
                            r_state <= S_MUL;
                            r_sgn   <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_acc   <= {1'b0, w_b_mag[0] ? w_a_mag : '0};
                            r_d     <= w_a_mag << 1;
                            r_q     <= w_b_mag >> 1;
                        end else begin
                            r_state <= S_DIV;
                            r_sgn   <= (op == ALU_DIV) ? a[WIDTH-1] ^ b[WIDTH-1]
                                                       : a[WIDTH-1];
                            r_d     <= w_b_mag;
                            {r_acc, r_q} <= div_step('0, w_a_mag, w_b_mag);
                        end
                    end
                    S_MUL: begin
                        r_acc <= {1'b0, r_acc[WIDTH-1:0] + (r_q[0] ? r_d : '0)};
                        r_d   <= r_d << 1;
                        r_q   <= r_q >> 1;
                        if (r_cnt == '0) r_state <= S_FIX;
                        else r_cnt <= r_cnt - 1'b1;
                    end
                    S_DIV: begin
                        {r_acc, r_q} <= div_step(r_acc, r_q, r_d);
                        if (r_cnt == '0) r_state <= S_FIX;
                        else r_cnt <= r_cnt - 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
                if (w_load) begin
                    r_y    <= w_ynext;
                    r_zero <= w_znext;
                    r_ov   <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_ov;
    assign y         = r_y;
    assign zero      = r_zero;

`ifdef ALU_EXT_FLAGS_EN
    logic w_c_next;
    logic w_o_next;
    logic r_neg;
    logic r_carry;
    logic r_ovf;

    // Flags derived from the MSBs of operands and the simple-path sum.
    always_comb begin
        w_c_next = 1'b0;
        w_o_next = 1'b0;
        if (r_state == S_IDLE && op == ALU_ADD) begin
            w_c_next = (a[WIDTH-1] & b[WIDTH-1])
                     | ((a[WIDTH-1] | b[WIDTH-1]) & ~w_sy[WIDTH-1]);
            w_o_next = (a[WIDTH-1] == b[WIDTH-1])
                     && (w_sy[WIDTH-1] != a[WIDTH-1]);
        end else if (r_state == S_IDLE && op == ALU_SUB) begin
            w_c_next = (a[WIDTH-1] & ~b[WIDTH-1])
                     | ((a[WIDTH-1] | ~b[WIDTH-1]) & ~w_sy[WIDTH-1]);
            w_o_next = (a[WIDTH-1] != b[WIDTH-1])
                     && (w_sy[WIDTH-1] != a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (!flush && w_load) begin
            r_neg   <= w_ynext[WIDTH-1];
            r_carry <= w_c_next;
            r_ovf   <= w_o_next;
        end
    end

    assign neg   = r_neg;
    assign carry = r_carry;
    assign ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed scenarios plus
// randomized ops against an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 32;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] SLL  = 4'd6;
    localparam logic [3:0] XOR_ = 4'd4;
    localparam logic [3:0] MUL  = 4'd11;
    localparam logic [3:0] DIV  = 4'd12;
    localparam logic [3:0] MOD  = 4'd13;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic         zero;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] y;
    logic [3:0]   op = '0;
`ifdef ALU_EXT_FLAGS_EN
    logic neg, carry, ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero)
`ifdef ALU_EXT_FLAGS_EN
       ,.neg(neg), .carry(carry), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: returns {zero, y} from plain arithmetic on the op rules.
    function automatic logic [W:0] model(input logic [3:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] z);
        longint sx, sz;
        logic [63:0] r;
        logic [W-1:0] ry;
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        ry = '0;
        case (o)
            0: ry = x + z;
            1: ry = x - z;
            2: ry = x & z;
            3: ry = x | z;
            4: ry = x ^ z;
            5: ry = (sx < sz) ? 1 : 0;
            6: ry = x << z[4:0];
            7: ry = x >> z[4:0];
            8: ry = $signed(x) >>> z[4:0];
            9: ry = z;
            10: ry = ~z;
            11: begin r = sx * sz; ry = r[W-1:0]; end
            12: begin
                if (z == 0) return {1'b1, {W{1'b1}}};
                r = sx / sz; ry = r[W-1:0];
            end
            13: begin
                if (z == 0) return {1'b0, x};
                r = sx % sz; ry = r[W-1:0];
            end
            default: ry = '0;
        endcase
        return {ry == 0, ry};
    endfunction

    function automatic int exp_lat(input logic [3:0] o, input logic [W-1:0] z);
        if (o == MUL || ((o == DIV || o == MOD) && z != 0)) return W + 1;
        return 1;
    endfunction

    // Issue one op and wait (bounded) for its result; operands scrambled while busy.
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] z, output int lat,
                         output logic [W-1:0] ry, output logic rz);
        op = o; a = x; b = z; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 80) begin
            tick();
            lat++;
        end
        ry = y;
        rz = zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || y !== '0 || zero !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset: ov=%b y=%h z=%b rdy=%b, want 0 0 0 0",
                     out_valid, y, zero, in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        op = ADD; a = 32'h7FFFFFFF; b = 32'h1; in_valid = 1'b1;
        tick();
        op = SUB; a = 32'd5; b = 32'd5;
        n_cmp++;
        if (out_valid !== 1'b1 || y !== 32'h80000000 || zero !== 1'b0
            || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_add: ov=%b y=%h z=%b rdy=%b want 1 80000000 0 1",
                     out_valid, y, zero, in_ready);
        end
`ifdef ALU_EXT_FLAGS_EN
        n_cmp++;
        if (ovf !== 1'b1 || carry !== 1'b0 || neg !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_add_flags: ovf=%b c=%b n=%b want 1 0 1", ovf, carry, neg);
        end
`endif
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || y !== '0 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_sub: ov=%b y=%h z=%b want 1 0 1", out_valid, y, zero);
        end
`ifdef ALU_EXT_FLAGS_EN
        n_cmp++;
        if (carry !== 1'b1 || ovf !== 1'b0 || neg !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_sub_flags: c=%b ovf=%b n=%b want 1 0 0", carry, ovf, neg);
        end
`endif
        tick();
    endtask

    task automatic test_mul();
        logic bad;
        int lat;
        logic [W-1:0] ry;
        logic rz;
        op = MUL; a = -32'sd7; b = 32'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        bad = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
            tick();
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL mul_busy: in_ready/out_valid not 0 during T+1..T+32");
        end
        n_cmp++;
        if (out_valid !== 1'b1 || y !== 32'hFFFFFFD6 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL mul_res: ov=%b y=%h z=%b want 1 FFFFFFD6 0",
                     out_valid, y, zero);
        end
        do_op(SLL, 32'd1, 32'd33, lat, ry, rz);
        n_cmp++;
        if (lat !== 1 || ry !== 32'd2 || rz !== 1'b0) begin
            n_err++;
            $display("FAIL sll33: lat=%0d y=%h z=%b want 1 00000002 0", lat, ry, rz);
        end
    endtask

    task automatic test_div();
        logic [3:0]   t_op[6] = '{DIV, MOD, DIV, MOD, DIV, MOD};
        logic [W-1:0] t_a[6]  = '{-32'sd17, -32'sd17, 32'h80000000,
                                  32'h80000000, 32'd100, 32'd100};
        logic [W-1:0] t_b[6]  = '{32'd5, 32'd5, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'd0, 32'd0};
        logic [W-1:0] t_y[6]  = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'h80000000,
                                  32'h0, 32'hFFFFFFFF, 32'h64};
        logic         t_z[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int           t_l[6]  = '{33, 33, 33, 33, 1, 1};
        int lat;
        logic [W-1:0] ry;
        logic rz;
        for (int i = 0; i < 6; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], lat, ry, rz);
            n_cmp++;
            if (lat !== t_l[i] || ry !== t_y[i] || rz !== t_z[i]) begin
                n_err++;
                $display("FAIL div[%0d]: lat=%0d y=%h z=%b want %0d %h %b",
                         i, lat, ry, rz, t_l[i], t_y[i], t_z[i]);
            end
        end
        tick();
    endtask

    task automatic test_hold();
        logic [W-1:0] x1, z1, x2, z2, hy;
        logic hz, bad;
        x1 = $urandom; z1 = $urandom; x2 = $urandom; z2 = $urandom;
        out_ready = 1'b0;
        op = ADD; a = x1; b = z1; in_valid = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || y !== x1 + z1) begin
            n_err++;
            $display("FAIL hold_first: ov=%b y=%h want 1 %h", out_valid, y, x1 + z1);
        end
        hy = y; hz = zero;
        op = XOR_; a = x2; b = z2;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (out_valid !== 1'b1 || y !== hy || zero !== hz || in_ready !== 1'b0)
                bad = 1'b1;
            tick();
        end
        n_cmp++;
        if (bad || out_valid !== 1'b1 || y !== hy) begin
            n_err++;
            $display("FAIL hold_stable: ov=%b y=%h want 1 %h, in_ready 0", out_valid, y, hy);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release: in_ready=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || y !== (x2 ^ z2)) begin
            n_err++;
            $display("FAIL hold_next: ov=%b y=%h want 1 %h", out_valid, y, x2 ^ z2);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_drain: ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] hy;
        logic seen;
        hy = y;
        op = DIV; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        flush = 1'b1;
        op = ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready: in_ready=%b want 0 during flush", in_ready);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after: rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_cmp++;
        if (seen || y !== hy) begin
            n_err++;
            $display("FAIL flush_quiet: seen=%b y=%h want 0 %h", seen, y, hy);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        op = MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || y !== '0 || zero !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: ov=%b y=%h z=%b rdy=%b want 0 0 0 0",
                     out_valid, y, zero, in_ready);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_mid_quiet: out_valid rose after reset abort");
        end
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] x, z, ry;
        logic [3:0] o;
        logic rz;
        logic [W:0] m;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            case ($urandom_range(0, 3))
                0: z = 32'($urandom_range(0, 40));
                1: z = '0;
                2: z = -32'($urandom_range(1, 40));
                default: z = $urandom;
            endcase
            m = model(o, x, z);
            do_op(o, x, z, lat, ry, rz);
            n_cmp++;
            if (lat !== exp_lat(o, z) || ry !== m[W-1:0] || rz !== m[W]) begin
                n_err++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: lat=%0d y=%h z=%b want %0d %h %b",
                         i, o, x, z, lat, ry, rz, exp_lat(o, z), m[W-1:0], m[W]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul();
        test_div();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
